// File: rtl/alu_bcd_conv.sv
// Binary-to-BCD converter for the 8-bit ALU result (sign/magnitude aware).
// Ports: clk/rst, start + result/sign/overflow capture; bcd_hund/tens/ones,
//        neg, ovf, busy and a one-cycle done pulse; 9 cycles start-to-done.
module alu_bcd_conv (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] result,
  input  logic       sign,
  input  logic       overflow,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       neg,
  output logic       ovf,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [19:0] scratch;
  logic [19:0] adjusted;
  logic [19:0] shifted;
  logic [3:0]  cnt;
  logic        neg_cap;
  logic        ovf_cap;
  logic [7:0]  magnitude;

  // Two's complement negate; 0x80 stays 0x80, which reads as 128 unsigned.
  assign magnitude = sign ? (~result + 8'd1) : result;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Only the three BCD fields are corrected; the low byte is still binary.
  assign adjusted = {add3(scratch[19:16]), add3(scratch[15:12]),
                     add3(scratch[11:8]), scratch[7:0]};
  assign shifted  = {adjusted[18:0], 1'b0};

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      // cnt still holds the pre-increment value, so 7 marks the 8th shift.
      SHIFT:   if (cnt == 4'd7) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scratch  <= 20'd0;
      cnt      <= 4'd0;
      neg_cap  <= 1'b0;
      ovf_cap  <= 1'b0;
      bcd_hund <= 4'd0;
      bcd_tens <= 4'd0;
      bcd_ones <= 4'd0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            scratch <= {12'd0, magnitude};
            cnt     <= 4'd0;
            neg_cap <= sign;
            ovf_cap <= overflow;
          end
        end
        SHIFT: begin
          scratch <= shifted;
          cnt     <= cnt + 4'd1;
        end
        FINISH: begin
          bcd_hund <= scratch[19:16];
          bcd_tens <= scratch[15:12];
          bcd_ones <= scratch[11:8];
          neg      <= neg_cap;
          ovf      <= ovf_cap;
          done     <= 1'b1;
        end
        default: begin
          scratch <= 20'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bcd_conv.sv
module tb_alu_bcd_conv;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] result;
  logic       sign;
  logic       overflow;
  logic [3:0] bcd_hund;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       neg;
  logic       ovf;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Last values the outputs are expected to hold.
  int exp_h = 0, exp_t = 0, exp_o = 0, exp_neg = 0, exp_ovf = 0;

  alu_bcd_conv dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .result   (result),
    .sign     (sign),
    .overflow (overflow),
    .bcd_hund (bcd_hund),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .neg      (neg),
    .ovf      (ovf),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_hund"}, int'(bcd_hund), exp_h);
    check({tag, "_tens"}, int'(bcd_tens), exp_t);
    check({tag, "_ones"}, int'(bcd_ones), exp_o);
    check({tag, "_neg"},  int'(neg),      exp_neg);
    check({tag, "_ovf"},  int'(ovf),      exp_ovf);
  endtask

  // Reference: decimal digits of the signed/unsigned magnitude.
  task automatic model(input int r, input int s, input int o,
                       output int h, output int t, output int u);
    int mag;
    mag = s ? ((256 - r) % 256) : r;
    h = mag / 100;
    t = (mag / 10) % 10;
    u = mag % 10;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, then walks E1..E9. inj_at > 0 re-pulses start after
  // that shift edge with a different value, which must be ignored.
  task automatic convert(input int r, input int s, input int o, input int inj_at);
    int h, t, u;
    model(r, s, o, h, t, u);
    result   = r[7:0];
    sign     = s[0];
    overflow = o[0];
    start    = 1'b1;
    tick();                                   // E0
    start    = 1'b0;
    result   = 8'($urandom);
    sign     = 1'($urandom);
    overflow = 1'($urandom);
    check("busy_after_e0", int'(busy), 1);
    for (int i = 1; i <= 9; i++) begin
      tick();
      start = (i == inj_at) ? 1'b1 : 1'b0;
      if (i == inj_at) result = 8'd7;
      if (i < 9) begin
        check("busy_mid", int'(busy), 1);
        check("done_mid", int'(done), 0);
        if (i == 4) check_outputs("hold_mid");
      end else begin
        exp_h = h; exp_t = t; exp_o = u; exp_neg = s; exp_ovf = o;
        check("done_e9", int'(done), 1);
        check("busy_e9", int'(busy), 0);
        check_outputs("result");
      end
    end
  endtask

  task automatic idle_check();
    tick();
    check("done_one_cycle", int'(done), 0);
    check("busy_idle", int'(busy), 0);
    check_outputs("hold_idle");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; result = 8'd0; sign = 1'b0; overflow = 1'b0;
    #22;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check_outputs("rst");
    rst = 1'b0;
    tick();

    // Directed cases.
    convert(25, 0, 0, 0);     idle_check();
    convert(255, 0, 0, 0);    idle_check();
    convert(0, 0, 0, 0);      idle_check();
    convert(8'hF6, 1, 0, 0);  idle_check();
    convert(8'h80, 1, 0, 0);  idle_check();
    convert(8'h82, 1, 1, 0);  idle_check();

    // Ignored start at E4, then a request in the done cycle.
    convert(99, 0, 0, 4);
    convert(7, 0, 0, 0);      idle_check();

    // Reset mid-conversion (shortly after E5).
    result = 8'd200; sign = 1'b0; overflow = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    exp_h = 0; exp_t = 0; exp_o = 0; exp_neg = 0; exp_ovf = 0;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(done), 0);
    check_outputs("rst_mid");
    tick();
    #3 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("no_done_after_rst", int'(done), 0);
    end
    convert(42, 0, 0, 0);     idle_check();

    // Randomized conversions; some chained back-to-back, some with a stray start.
    for (int n = 0; n < 40; n++) begin
      int r, s, o, inj;
      r   = int'($urandom_range(0, 255));
      s   = int'($urandom_range(0, 1));
      o   = int'($urandom_range(0, 1));
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      convert(r, s, o, inj);
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
